// File: rtl/wb_stage.sv
// Write-back stage: retires execute results, aligns load data returned by memory,
// and drives the register-file write port plus the difftest commit outputs.
module wb_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [63:0] ex_pc,
   input  logic [31:0] ex_inst,
   input  logic [4:0]  ex_rd,
   input  logic        ex_rd_wen,
   input  logic [63:0] ex_alu_result,
   input  logic        ex_is_load,
   input  logic [1:0]  ex_load_size,
   input  logic        ex_load_unsigned,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata,
   output logic [4:0]  WriteAddr,
   output logic [63:0] WriteData,
   output logic        WriteEnable,
   output logic        commit_valid,
   output logic [63:0] commit_pc,
   output logic [31:0] commit_inst,
   output logic        commit_wen,
   output logic [4:0]  commit_wdest,
   output logic [63:0] commit_wdata
);

   typedef enum logic {IDLE, WAIT_LOAD} state_t;

   state_t      state;
   logic        accept;

   logic [63:0] ld_pc;
   logic [31:0] ld_inst;
   logic [4:0]  ld_rd;
   logic        ld_rd_wen;
   logic [2:0]  ld_off;
   logic [1:0]  ld_size;
   logic        ld_unsigned;

   logic [63:0] shifted;
   logic [63:0] load_data;

   logic        wb_fire;
   logic        wb_we;
   logic [63:0] wb_pc;
   logic [31:0] wb_inst;
   logic [4:0]  wb_rd;
   logic        wb_rd_wen;
   logic [63:0] wb_data;

   assign ex_ready = (state == IDLE);
   assign accept   = ex_valid & ex_ready;

   // Doubles ignore the offset; lanes shifted in from above bit 63 are zero.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      shifted   = mem_rdata >> {((ld_size == 2'b11) ? 3'd0 : ld_off), 3'b000};
      load_data = shifted;
      case (ld_size)
         2'b00:   load_data = ld_unsigned ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
         2'b01:   load_data = ld_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
         2'b10:   load_data = ld_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
         default: load_data = shifted;
      endcase
   end

   always_comb begin
      wb_fire   = 1'b0;
      wb_pc     = 64'd0;
      wb_inst   = 32'd0;
      wb_rd     = 5'd0;
      wb_rd_wen = 1'b0;
      wb_data   = 64'd0;
      if (state == IDLE && accept && !ex_is_load) begin
         wb_fire   = 1'b1;
         wb_pc     = ex_pc;
         wb_inst   = ex_inst;
         wb_rd     = ex_rd;
         wb_rd_wen = ex_rd_wen;
         wb_data   = ex_alu_result;
      end else if (state == WAIT_LOAD && mem_rvalid) begin
         wb_fire   = 1'b1;
         wb_pc     = ld_pc;
         wb_inst   = ld_inst;
         wb_rd     = ld_rd;
         wb_rd_wen = ld_rd_wen;
         wb_data   = load_data;
      end
      wb_we = wb_fire & wb_rd_wen & (wb_rd != 5'd0);
   end

   // Address and data are zeroed whenever no write happens so the regfile bypass sees nothing stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         WriteEnable  <= 1'b0;
         WriteAddr    <= 5'd0;
         WriteData    <= 64'd0;
         commit_valid <= 1'b0;
         commit_pc    <= 64'd0;
         commit_inst  <= 32'd0;
         commit_wen   <= 1'b0;
         commit_wdest <= 5'd0;
         commit_wdata <= 64'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         case (state)
            IDLE:      if (accept && ex_is_load) state <= WAIT_LOAD;
            WAIT_LOAD: if (mem_rvalid)           state <= IDLE;
            default:                             state <= IDLE;
         endcase
         WriteEnable  <= wb_we;
         WriteAddr    <= wb_we ? wb_rd   : 5'd0;
         WriteData    <= wb_we ? wb_data : 64'd0;
         commit_valid <= wb_fire;
         commit_pc    <= wb_pc;
         commit_inst  <= wb_inst;
         commit_wen   <= wb_we;
         commit_wdest <= wb_we ? wb_rd   : 5'd0;
         commit_wdata <= wb_we ? wb_data : 64'd0;
      end
   end

   // NOTE: pure capture registers need no reset; they are only read in WAIT_LOAD, which reset leaves.
   always_ff @(posedge clk) begin
      if (accept && ex_is_load) begin
         ld_pc       <= ex_pc;
         ld_inst     <= ex_inst;
         ld_rd       <= ex_rd;
         ld_rd_wen   <= ex_rd_wen;
         ld_off      <= ex_alu_result[2:0];
         ld_size     <= ex_load_size;
         ld_unsigned <= ex_load_unsigned;
      end
   end

endmodule
